// File: rtl/obstacle_spawner.sv
// Obstacle spawner for the dino game.
// Draws one random word per obstacle, waits a level-dependent number of game ticks,
// then offers the obstacle to the scroller over a valid/ready handshake. Accepted
// spawns raise the difficulty level, which narrows the gap range and unlocks birds.
module obstacle_spawner #(
  parameter int unsigned MIN_GAP          = 16,
  parameter int unsigned GAP_W            = 6,
  parameter int unsigned SPAWNS_PER_LEVEL = 8,
  parameter int unsigned BIRD_LEVEL       = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        tick_i,
  input  logic [15:0] rand_i,
  output logic        rand_next_o,
  output logic        spawn_valid_o,
  input  logic        spawn_ready_i,
  output logic [1:0]  spawn_kind_o,
  output logic [2:0]  level_o
);

  localparam int unsigned CntW    = (SPAWNS_PER_LEVEL > 1) ? $clog2(SPAWNS_PER_LEVEL) : 1;
  localparam int unsigned GapCntW = GAP_W + 1;
  localparam int unsigned LvlW    = 3;

  localparam logic [LvlW-1:0]    LvlMax  = LvlW'(GAP_W);
  localparam logic [CntW-1:0]    CntLast = CntW'(SPAWNS_PER_LEVEL - 1);
  localparam logic [GapCntW-1:0] MinGap  = GapCntW'(MIN_GAP);
  localparam logic [GapCntW-1:0] GapOne  = GapCntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StDraw,
    StWait,
    StSpawn
  } state_e;

  state_e state_q, state_d;

  logic [GapCntW-1:0] gap_cnt_q, gap_cnt_d;
  logic [1:0]         kind_q, kind_d;
  logic [CntW-1:0]    spawn_cnt_q, spawn_cnt_d;
  logic [LvlW-1:0]    level_q, level_d;

  logic               rand_next_q, rand_next_d;
  logic               spawn_valid_q, spawn_valid_d;
  logic [1:0]         spawn_kind_q, spawn_kind_d;

  logic [GAP_W-1:0]   gap_field;
  logic               accept;
  logic               unused_rand;

  // Only the gap field and the kind bits are consumed; the rest of the word is ignored.
  assign unused_rand = ^rand_i;

  assign accept = (state_q == StSpawn) && spawn_ready_i;

  // Random gap shrinks by one bit of range per level; at level GAP_W it is zero.
  assign gap_field = rand_i[GAP_W-1:0] >> level_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; disable wins over any tick or handshake in the same cycle.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StDraw;
        StDraw:  state_d = StWait;
        StWait: begin
          if (tick_i && (gap_cnt_q == GapOne)) begin
            state_d = StSpawn;
          end
        end
        StSpawn: begin
          if (spawn_ready_i) begin
            state_d = StDraw;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath next-state: gap countdown, kind latch and difficulty tracking.
  always_comb begin
    gap_cnt_d   = gap_cnt_q;
    kind_d      = kind_q;
    spawn_cnt_d = spawn_cnt_q;
    level_d     = level_q;
    if (state_d == StIdle) begin
      // Leaving or sitting in idle forgets all difficulty progress.
      gap_cnt_d   = '0;
      kind_d      = 2'd0;
      spawn_cnt_d = '0;
      level_d     = '0;
    end else begin
      unique case (state_q)
        StDraw: begin
          gap_cnt_d = MinGap + GapCntW'(gap_field);
          unique case (rand_i[15:14])
            2'b00, 2'b01: kind_d = 2'd0;
            2'b10:        kind_d = 2'd1;
            default: begin
              if (32'(level_q) >= BIRD_LEVEL) begin
                kind_d = {1'b1, rand_i[13]};
              end else begin
                kind_d = 2'd1;
              end
            end
          endcase
        end
        StWait: begin
          if (tick_i) begin
            gap_cnt_d = gap_cnt_q - GapOne;
          end
        end
        StSpawn: begin
          if (accept) begin
            if (spawn_cnt_q == CntLast) begin
              spawn_cnt_d = '0;
              if (level_q < LvlMax) begin
                level_d = level_q + 1'b1;
              end
            end else begin
              spawn_cnt_d = spawn_cnt_q + CntW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    rand_next_d   = (state_d == StDraw);
    spawn_valid_d = (state_d == StSpawn);
    spawn_kind_d  = (state_d == StSpawn) ? kind_d : 2'd0;
  end

  // Output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rand_next_q   <= 1'b0;
      spawn_valid_q <= 1'b0;
      spawn_kind_q  <= 2'd0;
    end else begin
      rand_next_q   <= rand_next_d;
      spawn_valid_q <= spawn_valid_d;
      spawn_kind_q  <= spawn_kind_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap_cnt_q   <= '0;
      kind_q      <= 2'd0;
      spawn_cnt_q <= '0;
      level_q     <= '0;
    end else begin
      gap_cnt_q   <= gap_cnt_d;
      kind_q      <= kind_d;
      spawn_cnt_q <= spawn_cnt_d;
      level_q     <= level_d;
    end
  end

  assign rand_next_o   = rand_next_q;
  assign spawn_valid_o = spawn_valid_q;
  assign spawn_kind_o  = spawn_kind_q;
  assign level_o       = level_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// Directed bench for obstacle_spawner: expected gap/kind pairs are queued when the
// random word for a draw is driven and compared when the offer appears.
module tb_obstacle_spawner;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        tick_i = 1'b0;
  logic [15:0] rand_i = 16'h0000;
  logic        spawn_ready_i = 1'b0;
  logic        rand_next_o;
  logic        spawn_valid_o;
  logic [1:0]  spawn_kind_o;
  logic [2:0]  level_o;

  always #5 clk_i = ~clk_i;

  obstacle_spawner #(
    .MIN_GAP          (16),
    .GAP_W            (6),
    .SPAWNS_PER_LEVEL (8),
    .BIRD_LEVEL       (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .tick_i        (tick_i),
    .rand_i        (rand_i),
    .rand_next_o   (rand_next_o),
    .spawn_valid_o (spawn_valid_o),
    .spawn_ready_i (spawn_ready_i),
    .spawn_kind_o  (spawn_kind_o),
    .level_o       (level_o)
  );

  typedef struct {
    int         gap;
    logic [1:0] kind;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         acc = 0;
  logic [1:0] cur_kind = 2'd0;

  function automatic int lvl_of(input int a);
    int l;
    l = a / 8;
    return (l > 6) ? 6 : l;
  endfunction

  function automatic int gap_of(input logic [15:0] r, input int l);
    return 16 + (int'(r[5:0]) >> l);
  endfunction

  function automatic logic [1:0] kind_of(input logic [15:0] r, input int l);
    case (r[15:14])
      2'b00, 2'b01: return 2'd0;
      2'b10:        return 2'd1;
      default:      return (l >= 2) ? {1'b1, r[13]} : 2'd1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] r);
    exp_t e;
    e.gap  = gap_of(r, lvl_of(acc));
    e.kind = kind_of(r, lvl_of(acc));
    sb.push_back(e);
  endtask

  // Runs from the current negedge until an offer appears, ticking every `period` cycles.
  task automatic run_to_offer(input int period, input string tag);
    int   ticks;
    int   draws;
    int   last;
    int   cyc;
    bit   in_wait;
    exp_t e;
    ticks   = 0;
    draws   = 0;
    last    = -10;
    in_wait = 1'b0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      if (spawn_valid_o === 1'b1) break;
      if (rand_next_o === 1'b1) draws++;
      tick_i = ((cyc % period) == (period - 1));
      if (tick_i && in_wait) begin
        ticks++;
        last = cyc;
      end
      if (rand_next_o === 1'b1) in_wait = 1'b1;
      @(negedge clk_i);
    end
    tick_i = 1'b0;
    check({tag, "_offer"}, spawn_valid_o, 1);
    check({tag, "_sb_entry"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.gap  = 0;
      e.kind = 2'd0;
    end
    check({tag, "_gap"}, ticks, e.gap);
    check({tag, "_kind"}, spawn_kind_o, e.kind);
    check({tag, "_draws"}, draws, 1);
    check({tag, "_rise"}, cyc, last + 1);
    cur_kind = e.kind;
  endtask

  // Holds the offer for `hold` cycles with ticks present, then accepts it.
  task automatic accept(input logic [15:0] r_next, input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      tick_i = 1'b1;
      @(negedge clk_i);
      check({tag, "_hold_valid"}, spawn_valid_o, 1);
      check({tag, "_hold_kind"}, spawn_kind_o, cur_kind);
      check({tag, "_hold_no_next"}, rand_next_o, 0);
    end
    tick_i        = 1'b0;
    spawn_ready_i = 1'b1;
    rand_i        = r_next;
    acc++;
    push_exp(r_next);
    @(negedge clk_i);
    spawn_ready_i = 1'b0;
    check({tag, "_draw_after_acc"}, rand_next_o, 1);
    check({tag, "_valid_drop"}, spawn_valid_o, 0);
    check({tag, "_level"}, level_o, lvl_of(acc));
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk_i);
    check("rst_rand_next", rand_next_o, 0);
    check("rst_valid", spawn_valid_o, 0);
    check("rst_kind", spawn_kind_o, 0);
    check("rst_level", level_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("idle_rand_next", rand_next_o, 0);

    // Basic spawn: gap 21, kind 0, ticks every 4 cycles.
    acc    = 0;
    rand_i = 16'h0005;
    push_exp(rand_i);
    enable_i = 1'b1;
    run_to_offer(4, "basic");

    // Backpressure for 10 cycles, then a large cactus at level 0.
    accept(16'hC000, 10, "bp");
    run_to_offer(2, "kind_c000_l0");

    // Widest gap, then climb to level 2.
    accept(16'h003F, 0, "gap79");
    run_to_offer(1, "gap79");
    while (acc < 16) begin
      accept(16'h003F, 0, $sformatf("lvl_a%0d", acc + 1));
      run_to_offer(1, $sformatf("lvl_s%0d", acc));
    end

    // Kind mapping with birds unlocked.
    accept(16'hE000, 0, "bird_hi");
    run_to_offer(1, "bird_hi");
    accept(16'hC000, 0, "bird_lo");
    run_to_offer(1, "bird_lo");
    accept(16'h8000, 0, "large");
    run_to_offer(1, "large");
    accept(16'h4000, 0, "small");
    run_to_offer(1, "small");

    // Up to and past level saturation.
    while (acc < 56) begin
      accept(16'h003F, 0, $sformatf("sat_a%0d", acc + 1));
      run_to_offer(1, $sformatf("sat_s%0d", acc));
    end

    // Disable mid-WAIT.
    accept(16'h0005, 0, "pre_dis");
    tick_i = 1'b1;
    repeat (5) @(negedge clk_i);
    enable_i = 1'b0;
    @(negedge clk_i);
    check("dis_wait_valid", spawn_valid_o, 0);
    check("dis_wait_next", rand_next_o, 0);
    check("dis_wait_level", level_o, 0);
    void'(sb.pop_front());
    acc = 0;
    repeat (3) @(negedge clk_i);
    tick_i = 1'b0;
    check("dis_idle_valid", spawn_valid_o, 0);
    check("dis_idle_next", rand_next_o, 0);

    // Disable mid-SPAWN coincident with ready.
    rand_i = 16'h0005;
    push_exp(rand_i);
    enable_i = 1'b1;
    run_to_offer(1, "re_en");
    enable_i      = 1'b0;
    spawn_ready_i = 1'b1;
    @(negedge clk_i);
    spawn_ready_i = 1'b0;
    check("dis_spawn_valid", spawn_valid_o, 0);
    check("dis_spawn_next", rand_next_o, 0);
    check("dis_spawn_level", level_o, 0);
    check("dis_spawn_kind", spawn_kind_o, 0);

    // Eight fresh accepts are needed for level 1: the aborted spawn was not counted.
    acc    = 0;
    rand_i = 16'h0005;
    push_exp(rand_i);
    enable_i = 1'b1;
    run_to_offer(1, "re_en2");
    repeat (8) begin
      accept(16'h0005, 0, $sformatf("recount_a%0d", acc + 1));
      run_to_offer(1, $sformatf("recount_s%0d", acc));
    end

    // Async reset between edges during WAIT.
    accept(16'h0005, 0, "pre_rst");
    tick_i = 1'b1;
    repeat (3) @(negedge clk_i);
    tick_i = 1'b0;
    check("pre_rst_level", level_o, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_level", level_o, 0);
    check("arst_valid", spawn_valid_o, 0);
    check("arst_next", rand_next_o, 0);
    check("arst_kind", spawn_kind_o, 0);
    void'(sb.pop_front());
    acc = 0;
    @(negedge clk_i);
    rand_i = 16'h0007;
    push_exp(rand_i);
    rst_ni = 1'b1;
    run_to_offer(1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/obstacle_spawner.md
# obstacle_spawner

Consumer of the 16-bit LFSR random stream in the dino game. Draws a random inter-obstacle gap and obstacle kind, then counts game ticks. When the gap expires, it offers one obstacle to the scroller over a valid/ready handshake. Difficulty rises with accepted spawns: the random gap range narrows, and birds become legal after a threshold level. It pulses the generator's advance input once per draw, so each obstacle consumes exactly one random word.

## Interface
- MIN_GAP, 16: minimum gap in ticks; legal range 1 to 2^GAP_W-1.
- GAP_W, 6: width of the random gap field taken from rand_i[GAP_W-1:0].
- SPAWNS_PER_LEVEL, 8: accepted spawns per level increment; must be ≥1.
- BIRD_LEVEL, 2: minimum level at which bird kinds may be emitted.
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- enable_i  in  1  game running; low aborts and clears difficulty
- tick_i  in  1  one-cycle game frame tick
- rand_i  in  16  current random word from the LFSR
- rand_next_o  out  1  one-cycle pulse advancing the LFSR
- spawn_valid_o  out  1  obstacle offer
- spawn_ready_i  in  1  scroller accepts the offer
- spawn_kind_o  out  2  obstacle kind: 0 small cactus, 1 large cactus, 2 bird low, 3 bird high
- level_o  out  3  current difficulty level, saturating at GAP_W

## Operation
- States: IDLE, DRAW, WAIT, SPAWN.
- IDLE: all outputs low. level_o and the spawn counter are held at 0. When enable_i=1, go to DRAW.
- DRAW (exactly one cycle):
  - Assert rand_next_o.
  - Latch gap_cnt = MIN_GAP + (rand_i[GAP_W-1:0] >> level).
  - Latch kind from rand_i[15:14]:
    - 00 or 01 → 0.
    - 10 → 1.
    - 11 → 2 + rand_i[13] if level ≥ BIRD_LEVEL; otherwise 1.
  - Go to WAIT.
- WAIT: each tick_i decrements gap_cnt. A tick_i with gap_cnt==1 goes to SPAWN.
- SPAWN:
  - spawn_valid_o=1 and spawn_kind_o=latched kind, both held stable until accepted.
  - On spawn_valid_o & spawn_ready_i:
    - Increment the spawn counter.
    - When the counter reaches SPAWNS_PER_LEVEL-1 at acceptance, it wraps to 0 and level increments, saturating at GAP_W.
    - Go to DRAW.
- Arithmetic:
  - gap_cnt is GAP_W+1 bits wide.
  - Maximum gap is MIN_GAP + 2^GAP_W - 1, which never overflows.
  - At level GAP_W, the gap is exactly MIN_GAP.
- Disable: enable_i=0 in any non-IDLE state moves to IDLE on the next edge, including mid-SPAWN.
  - spawn_valid_o drops without acceptance.
  - level and spawn counter clear to 0.
  - Disable takes priority over a simultaneous handshake or tick; that spawn is not counted.
- tick_i is ignored in IDLE, DRAW and SPAWN. Ticks are not accumulated while backpressured.
- rand_next_o is never asserted outside DRAW.

## Timing
- Reset (async assert, sync release behaviour of the flops):
  - state IDLE.
  - rand_next_o=0, spawn_valid_o=0, spawn_kind_o=0, level_o=0.
  - gap_cnt=0, spawn counter=0.
- Reset mid-operation clears everything immediately, with no spawn emitted.
- The cycle enable_i is first sampled high is IDLE. DRAW is the next cycle, and rand_next_o is high for exactly that cycle.
- rand_i is sampled in the DRAW cycle, before the LFSR advances. The next draw sees the advanced word.
- spawn_valid_o rises in the cycle after the clock edge that samples the gap-th tick_i in WAIT.
- After acceptance: DRAW next cycle, then WAIT. The minimum spacing from acceptance to the next offer is gap ticks plus 2 cycles.
- level_o updates in the cycle after the accepting edge. It affects the immediately following DRAW.
- All outputs are registered.

## Test plan
- Basic spawn and gap timing:
  - Stimulus: reset, enable_i=1, rand_i=16'h0005, tick_i every 4 cycles.
  - Response: one rand_next_o pulse; spawn_valid_o rises after the 21st tick; spawn_kind_o=0.
- Kind mapping:
  - Stimulus: rand_i=16'hC000 at level 0.
  - Response: kind 1.
  - Stimulus: after 16 accepted spawns (level 2), rand_i=16'hE000.
  - Response: kind 3; rand_i=16'hC000 gives kind 2; 16'h8000 gives kind 1; 16'h4000 gives kind 0.
- Backpressure:
  - Stimulus: spawn_ready_i=0 for 10 cycles with ticks present.
  - Response: spawn_valid_o and kind stable; no rand_next_o; after ready, DRAW follows one cycle later.
- Difficulty:
  - Stimulus: rand_i[5:0]=63.
  - Response: gap 79 at level 0; gap 47 after 8 accepts (level_o=1); gap 16 at level 6; level_o stays 6 after further accepts.
- Disable:
  - Stimulus: drop enable_i mid-WAIT, and separately mid-SPAWN coincident with spawn_ready_i=1.
  - Response: IDLE next cycle; spawn_valid_o=0; level_o=0; spawn not counted.
- Async reset:
  - Stimulus: assert rst_ni low between clock edges during WAIT.
  - Response: all outputs 0 immediately; re-enable restarts with a fresh DRAW.
